player_switch: RTL and testbench

//   Turn arbiter for the two-player TicTacToe game on DE1-SoC.

---
 rtl/player_switch.sv | 89 ++++++++
 tb/tb_player_switch.sv | 116 +++++++++++
 2 files changed

// File: rtl/player_switch.sv
// Turn arbiter for two-player TicTacToe: flips curPlayer once per accepted select rising edge.
// Optional macro PLAYER_SWITCH_SYNC_EN adds a 2-flop synchronizer on select (3-cycle press-to-toggle).
module player_switch #(
  parameter int   MAX_MOVES      = 9,
  parameter int   LOCKOUT_CYCLES = 2,
  parameter logic FIRST_PLAYER   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic select,
  output logic curPlayer
);

  localparam int LOCK_W = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
  localparam logic [3:0]        MOVES_MAX = 4'(MAX_MOVES);

  logic              sel_s;
  logic              sel_q, sel_d;
  logic              cur_q, cur_d;
  logic [3:0]        moves_q, moves_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              accept;
  logic              toggle;

  function automatic logic [LOCK_W-1:0] lock_dec(input logic [LOCK_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  function automatic logic [3:0] moves_inc(input logic [3:0] v);
    return (v >= MOVES_MAX) ? MOVES_MAX : v + 4'd1;
  endfunction

`ifdef PLAYER_SWITCH_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = select;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sel_s = sync2_q;
`else
  assign sel_s = select;
`endif

  // Edges seen during lockout or after the board fills are dropped, never queued.
  always_comb begin
    accept  = sel_s & ~sel_q;
    toggle  = accept && (lock_q == '0) && (moves_q < MOVES_MAX);
    sel_d   = sel_s;
    cur_d   = cur_q;
    moves_d = moves_q;
    lock_d  = lock_dec(lock_q);
    if (toggle) begin
      cur_d   = ~cur_q;
      moves_d = moves_inc(moves_q);
      lock_d  = LOCK_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q   <= 1'b0;
      cur_q   <= FIRST_PLAYER;
      moves_q <= 4'd0;
      lock_q  <= '0;
    end else begin
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      moves_q <= moves_d;
      lock_q  <= lock_d;
    end
  end

  assign curPlayer = cur_q;

endmodule

// File: tb/tb_player_switch.sv
// Scoreboard bench for player_switch (default build): driver queues hand-computed curPlayer per cycle.
module tb_player_switch;

  logic clk;
  logic reset;
  logic select;
  logic curPlayer;

  int   checks;
  int   errors;
  bit   drv_done;
  logic exp_q[$];

  player_switch #(
    .MAX_MOVES(9),
    .LOCKOUT_CYCLES(2),
    .FIRST_PLAYER(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .select(select),
    .curPlayer(curPlayer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs; exp is curPlayer after the following posedge.
  task automatic step(input logic rst_n, input logic sel, input logic exp);
    @(negedge clk);
    reset  = rst_n;
    select = sel;
    exp_q.push_back(exp);
  endtask

  task automatic press(input logic exp);
    step(1'b1, 1'b1, exp);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, exp);
  endtask

  initial begin
    reset    = 1'b0;
    drv_done = 1'b0;
    // Reset, then idle
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    // Single presses with idle gaps: 0->1->0->1
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    press(1'b0);
    press(1'b1);
    // Held select: one toggle only, then re-arm after a low sample
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    press(1'b1);
    // Lockout: edge 2 cycles later dropped, edge 4 later accepted
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    // Edge exactly 3 cycles after an accepted one is accepted
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    // Saturation: 12 presses, only 9 toggle
    step(1'b0, 1'b0, 1'b0);
    for (int p = 1; p <= 12; p++) press((p >= 9) ? 1'b1 : logic'(p % 2));
    step(1'b0, 1'b0, 1'b0);
    press(1'b1);
    // Reset mid-lockout, then immediate clean edge toggles
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    // Reset coincident with a rising edge: reset wins
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    press(1'b1);
    drv_done = 1'b1;
  end

  initial begin
    int   cyc;
    int   vec;
    logic e;
    checks = 0;
    errors = 0;
    cyc    = 0;
    vec    = 0;
    while (!(drv_done && exp_q.size() == 0) && cyc < 2000) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (curPlayer !== e) begin
          errors++;
          $display("FAIL curPlayer vec=%0d got=%b want=%b", vec, curPlayer, e);
        end
        vec++;
      end
      cyc++;
    end
    if (cyc >= 2000) begin
      errors++;
      checks++;
      $display("FAIL timeout pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
